// File: rtl/spi_txn_arbiter.sv
// Round-robin scheduler sharing one Mode-0 SPI master among NUM_REQ requesters.
// Launches one frame per grant, waits on cs with a watchdog, then acks and enforces an idle gap.
module spi_txn_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int CMD_BITS       = 8,
  parameter int ADDR_BITS      = 8,
  parameter int PAYLOAD_BITS   = 8,
  parameter int FRAME_W        = CMD_BITS + ADDR_BITS + PAYLOAD_BITS,
  parameter int RSP_W          = 7,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int GAP_CYCLES     = 4
) (
  input  logic                            sysclk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*CMD_BITS-1:0]     req_cmd,
  input  logic [NUM_REQ*ADDR_BITS-1:0]    req_addr,
  input  logic [NUM_REQ*PAYLOAD_BITS-1:0] req_payload,
  output logic [NUM_REQ-1:0]              ack,
  output logic [RSP_W-1:0]                rsp_data,
  output logic                            rsp_err,
  output logic                            busy,
  output logic                            m_tx_enb,
  output logic [FRAME_W-1:0]              m_frame,
  input  logic                            m_cs,
  input  logic [RSP_W-1:0]                m_rsp
);

  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WDOG_W = $clog2(TIMEOUT_CYCLES);
  localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LAUNCH     = 3'd1,
    S_WAIT_START = 3'd2,
    S_WAIT_END   = 3'd3,
    S_GAP        = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [PTR_W-1:0]    grant_q, grant_d;
  logic [WDOG_W-1:0]   wdog_q, wdog_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic [RSP_W-1:0]    rsp_q, rsp_d;
  logic                err_q, err_d;
  logic                busy_q;
  logic                tx_enb_q, tx_enb_d;
  logic [FRAME_W-1:0]  frame_q, frame_d;

  logic                rr_found_s;
  logic [PTR_W-1:0]    rr_grant_s;
  logic [FRAME_W-1:0]  grant_frame_s;
  logic                wdog_done_s;
  logic                gap_done_s;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v = {NUM_REQ{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  assign wdog_done_s = (wdog_q == WDOG_LAST);
  assign gap_done_s  = (gap_q == GAP_LAST);

  // Round-robin search starting just after the last grant; also muxes that requester's frame.
  always_comb begin
    logic [PTR_W-1:0] idx;
    logic             take;
    logic             sel;
    rr_found_s    = 1'b0;
    rr_grant_s    = ptr_q;
    grant_frame_s = {FRAME_W{1'b0}};
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx        = PTR_W'((int'(ptr_q) + i) % NUM_REQ);
      take       = req[idx] && !rr_found_s;
      rr_grant_s = take ? idx : rr_grant_s;
      rr_found_s = rr_found_s | take;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      sel           = (rr_grant_s == PTR_W'(i));
      grant_frame_s = sel ? {req_cmd[i*CMD_BITS +: CMD_BITS],
                             req_addr[i*ADDR_BITS +: ADDR_BITS],
                             req_payload[i*PAYLOAD_BITS +: PAYLOAD_BITS]} : grant_frame_s;
    end
  end

  // State register
  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (rr_found_s) state_d = S_LAUNCH;
        else            state_d = S_IDLE;
      end
      S_LAUNCH: state_d = S_WAIT_START;
      S_WAIT_START: begin
        if (!m_cs)            state_d = S_WAIT_END;
        else if (wdog_done_s) state_d = S_GAP;
        else                  state_d = S_WAIT_START;
      end
      S_WAIT_END: begin
        if (m_cs)             state_d = S_GAP;
        else if (wdog_done_s) state_d = S_GAP;
        else                  state_d = S_WAIT_END;
      end
      S_GAP: begin
        if (gap_done_s) state_d = S_IDLE;
        else            state_d = S_GAP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values; ack/rsp default to zero so they pulse for one cycle
  always_comb begin
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    wdog_d   = wdog_q;
    gap_d    = gap_q;
    ack_d    = {NUM_REQ{1'b0}};
    rsp_d    = {RSP_W{1'b0}};
    err_d    = 1'b0;
    tx_enb_d = 1'b0;
    frame_d  = frame_q;
    case (state_q)
      S_IDLE: begin
        if (rr_found_s) begin
          grant_d  = rr_grant_s;
          ptr_d    = rr_grant_s;
          frame_d  = grant_frame_s;
          tx_enb_d = 1'b1;
        end else begin
          tx_enb_d = 1'b0;
        end
      end
      S_LAUNCH: wdog_d = {WDOG_W{1'b0}};
      S_WAIT_START: begin
        if (!m_cs) begin
          wdog_d = {WDOG_W{1'b0}};
        end else if (wdog_done_s) begin
          ack_d = onehot(grant_q);
          err_d = 1'b1;
          gap_d = {GAP_W{1'b0}};
        end else begin
          wdog_d = wdog_q + WDOG_W'(1'b1);
        end
      end
      S_WAIT_END: begin
        if (m_cs) begin
          ack_d = onehot(grant_q);
          rsp_d = m_rsp;
          gap_d = {GAP_W{1'b0}};
        end else if (wdog_done_s) begin
          ack_d = onehot(grant_q);
          err_d = 1'b1;
          gap_d = {GAP_W{1'b0}};
        end else begin
          wdog_d = wdog_q + WDOG_W'(1'b1);
        end
      end
      S_GAP: gap_d = gap_q + GAP_W'(1'b1);
      default: ptr_d = ptr_q;
    endcase
  end

  // Datapath and registered outputs; pointer resets to the last index so req[0] wins first
  always_ff @(posedge sysclk) begin
    if (rst) begin
      ptr_q    <= PTR_W'(NUM_REQ - 1);
      grant_q  <= {PTR_W{1'b0}};
      wdog_q   <= {WDOG_W{1'b0}};
      gap_q    <= {GAP_W{1'b0}};
      ack_q    <= {NUM_REQ{1'b0}};
      rsp_q    <= {RSP_W{1'b0}};
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      tx_enb_q <= 1'b0;
      frame_q  <= {FRAME_W{1'b0}};
    end else begin
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      wdog_q   <= wdog_d;
      gap_q    <= gap_d;
      ack_q    <= ack_d;
      rsp_q    <= rsp_d;
      err_q    <= err_d;
      busy_q   <= (state_d != S_IDLE);
      tx_enb_q <= tx_enb_d;
      frame_q  <= frame_d;
    end
  end

  assign ack      = ack_q;
  assign rsp_data = rsp_q;
  assign rsp_err  = err_q;
  assign busy     = busy_q;
  assign m_tx_enb = tx_enb_q;
  assign m_frame  = frame_q;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Scoreboard bench for spi_txn_arbiter: a transaction-level model predicts grant order,
// frames and launch/ack timestamps; a mock SPI master plays a scripted cs profile per launch.
`timescale 1ns/1ps
module tb_spi_txn_arbiter;
  localparam int NR = 4, CB = 8, AB = 8, PB = 8, FW = 24, RW = 7;
  localparam int TO = 64, GP = 4;

  logic              sysclk = 1'b0;
  logic              rst = 1'b1;
  logic [NR-1:0]     req = '0;
  logic [NR*CB-1:0]  req_cmd = '0;
  logic [NR*AB-1:0]  req_addr = '0;
  logic [NR*PB-1:0]  req_payload = '0;
  logic [NR-1:0]     ack;
  logic [RW-1:0]     rsp_data;
  logic              rsp_err, busy, m_tx_enb;
  logic [FW-1:0]     m_frame;
  logic              m_cs = 1'b1;
  logic [RW-1:0]     m_rsp = '0;

  spi_txn_arbiter #(.NUM_REQ(NR), .CMD_BITS(CB), .ADDR_BITS(AB), .PAYLOAD_BITS(PB),
                    .FRAME_W(FW), .RSP_W(RW), .TIMEOUT_CYCLES(TO), .GAP_CYCLES(GP)) dut (
    .sysclk(sysclk), .rst(rst), .req(req), .req_cmd(req_cmd), .req_addr(req_addr),
    .req_payload(req_payload), .ack(ack), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .m_tx_enb(m_tx_enb), .m_frame(m_frame), .m_cs(m_cs), .m_rsp(m_rsp));

  always #5 sysclk = ~sysclk;

  int   cyc = 0;
  logic rst_p = 1'b0;
  always @(posedge sysclk) begin
    cyc   <= cyc + 1;
    rst_p <= rst;
  end

  typedef struct {
    int            s_edge;
    int            a_edge;
    logic [FW-1:0] frame;
    logic [NR-1:0] ackv;
    logic [RW-1:0] rsp;
    logic          err;
  } exp_t;
  typedef struct {
    int            mode;   // 0 normal, 1 cs never falls, 2 cs falls and sticks low
    int            d1;
    int            d2;
    logic [RW-1:0] rsp;
  } scr_t;

  exp_t exp_q[$];
  scr_t scr_q[$];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Requester data and model state
  logic [CB-1:0] dcmd [NR];
  logic [AB-1:0] daddr[NR];
  logic [PB-1:0] dpay [NR];
  int            rem  [NR];
  int            model_ptr = NR - 1;

  function automatic int rr_pick(input int p, input logic [NR-1:0] mask);
    for (int k = 1; k <= NR; k++) begin
      if (mask[(p + k) % NR]) return (p + k) % NR;
    end
    return -1;
  endfunction

  task automatic drive_data();
    for (int i = 0; i < NR; i++) begin
      req_cmd[i*CB +: CB]     = dcmd[i];
      req_addr[i*AB +: AB]    = daddr[i];
      req_payload[i*PB +: PB] = dpay[i];
    end
  endtask

  task automatic make_script(input int force_mode, output scr_t s);
    if (force_mode >= 0) s.mode = force_mode;
    else s.mode = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0;
    s.d1  = int'($urandom_range(1, 6));
    s.d2  = int'($urandom_range(1, 20));
    s.rsp = RW'($urandom);
  endtask

  // Expected ack edge from launch edge s: cs falls after d1 edges, rises after d2 more.
  function automatic int ack_edge(input int s, input scr_t sc);
    if (sc.mode == 0) return s + sc.d1 + sc.d2 + 1;
    if (sc.mode == 1) return s + 1 + TO;
    return s + sc.d1 + 1 + TO;
  endfunction

  task automatic push_txn(input int g, input int s, input scr_t sc, output int a);
    exp_t e;
    a        = ack_edge(s, sc);
    e.s_edge = s;
    e.a_edge = a;
    e.frame  = {dcmd[g], daddr[g], dpay[g]};
    e.ackv   = '0;
    e.ackv[g] = 1'b1;
    e.rsp    = (sc.mode == 0) ? sc.rsp : '0;
    e.err    = (sc.mode != 0);
    exp_q.push_back(e);
    scr_q.push_back(sc);
  endtask

  // Requesters in rem[] hold req until they have received rem[i] acks. Called at #1 after an edge, DUT idle.
  task automatic run_batch(input int force_mode);
    int            left[NR];
    int            p, s, a, g, total, n, bound;
    logic [NR-1:0] mask;
    scr_t          sc;
    total = 0;
    for (int i = 0; i < NR; i++) begin left[i] = rem[i]; total += rem[i]; end
    s = cyc + 1;
    p = model_ptr;
    for (int t = 0; t < total; t++) begin
      for (int i = 0; i < NR; i++) mask[i] = (left[i] > 0);
      g = rr_pick(p, mask);
      left[g]--;
      p = g;
      make_script(force_mode, sc);
      push_txn(g, s, sc, a);
      s = a + GP + 1;
    end
    model_ptr = p;
    drive_data();
    for (int i = 0; i < NR; i++) begin left[i] = rem[i]; req[i] = (rem[i] > 0); end
    bound = total * (2 * TO + 40) + 50;
    n = 0;
    while (req != '0 && n < bound) begin
      @(posedge sysclk); #1;
      n++;
      for (int i = 0; i < NR; i++) begin
        if (ack[i] && left[i] > 0) begin
          left[i]--;
          if (left[i] == 0) req[i] = 1'b0;
        end
      end
    end
    chk("batch_complete", 32'(req), 32'h0);
    req = '0;
    chk("batch_queue_drained", exp_q.size(), 0);
    repeat (GP + 1 + int'($urandom_range(0, 3))) @(posedge sysclk);
    #1;
  endtask

  // Mock SPI master: follows one script per observed launch
  initial begin
    scr_t s;
    forever begin
      @(posedge sysclk); #1;
      if (m_tx_enb && scr_q.size() > 0) begin
        s = scr_q.pop_front();
        m_rsp = ~s.rsp;
        if (s.mode == 0) begin
          repeat (s.d1) @(posedge sysclk);
          #1 m_cs = 1'b0;
          repeat (s.d2) @(posedge sysclk);
          #1 m_cs = 1'b1; m_rsp = s.rsp;
          @(posedge sysclk); #1 m_rsp = RW'($urandom);
        end else if (s.mode == 2) begin
          m_rsp = s.rsp | 7'h01;
          repeat (s.d1) @(posedge sysclk);
          #1 m_cs = 1'b0;
          for (int k = 0; k < 2 * TO + 50; k++) begin
            @(posedge sysclk); #1;
            if (ack != '0 || !busy) break;
          end
          m_cs = 1'b1;
        end else begin
          m_rsp = s.rsp | 7'h01;
        end
      end
    end
  end

  // Monitor: pops expectations on launch and on ack, checks idle values and busy every cycle
  initial begin
    exp_t          cur;
    bit            have_cur = 1'b0;
    logic [FW-1:0] last_frame = '0;
    int            idle_edge = 0;
    forever begin
      @(posedge sysclk); #1;
      if (rst_p) begin
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_tx_enb", 32'(m_tx_enb), 32'h0);
        chk("rst_frame", 32'(m_frame), 32'h0);
        chk("rst_rsp_data", 32'(rsp_data), 32'h0);
        chk("rst_rsp_err", 32'(rsp_err), 32'h0);
        have_cur = 1'b0; last_frame = '0; idle_edge = 0;
      end else begin
        if (m_tx_enb) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_launch", 32'h1, 32'h0);
          end else begin
            cur = exp_q.pop_front();
            have_cur = 1'b1;
            chk("launch_cycle", cyc, cur.s_edge);
            chk("launch_frame", 32'(m_frame), 32'(cur.frame));
            last_frame = cur.frame;
          end
        end else begin
          chk("frame_hold", 32'(m_frame), 32'(last_frame));
        end
        if (ack != '0) begin
          if (!have_cur) begin
            chk("unexpected_ack", 32'(ack), 32'h0);
          end else begin
            chk("ack_cycle", cyc, cur.a_edge);
            chk("ack_vector", 32'(ack), 32'(cur.ackv));
            chk("rsp_data", 32'(rsp_data), 32'(cur.rsp));
            chk("rsp_err", 32'(rsp_err), 32'(cur.err));
            have_cur = 1'b0;
            idle_edge = cyc + GP;
          end
        end else begin
          chk("rsp_data_idle", 32'(rsp_data), 32'h0);
          chk("rsp_err_idle", 32'(rsp_err), 32'h0);
          if (have_cur && cyc > cur.a_edge) begin
            chk("ack_missing", cyc, cur.a_edge);
            have_cur = 1'b0;
          end
        end
        chk("busy", 32'(busy), 32'(have_cur || cyc < idle_edge));
      end
    end
  end

  task automatic clear_rem();
    for (int i = 0; i < NR; i++) rem[i] = 0;
  endtask

  task automatic rand_data();
    for (int i = 0; i < NR; i++) begin
      dcmd[i] = CB'($urandom); daddr[i] = AB'($urandom); dpay[i] = PB'($urandom);
    end
  endtask

  initial begin
    int   s, a;
    scr_t sc;
    rand_data();
    repeat (3) @(posedge sysclk);
    #1 rst = 1'b0;
    @(posedge sysclk); #1;

    // Fairness: all four held, requester 0 wants two grants -> order 0,1,2,3,0
    clear_rem(); rand_data();
    for (int i = 0; i < NR; i++) dcmd[i] = CB'(8'h10 + i);
    rem[0] = 2; rem[1] = 1; rem[2] = 1; rem[3] = 1;
    run_batch(0);

    // Single request with a known frame
    clear_rem();
    dcmd[2] = 8'hA5; daddr[2] = 8'h10; dpay[2] = 8'h3C; rem[2] = 1;
    run_batch(0);
    chk("single_frame_held", 32'(m_frame), 32'h00A5103C);

    // Watchdog: cs never falls, then cs falls and sticks low
    clear_rem(); rand_data(); rem[3] = 1;
    run_batch(1);
    clear_rem(); rand_data(); rem[1] = 1;
    run_batch(2);

    // Reset in WAIT_END aborts silently; pointer restarts so req[0] wins next
    clear_rem(); rand_data(); drive_data();
    sc.mode = 0; sc.d1 = 2; sc.d2 = 30; sc.rsp = RW'($urandom);
    s = cyc + 1;
    push_txn(rr_pick(model_ptr, 4'b0001), s, sc, a);
    req = 4'b0001;
    repeat (12) @(posedge sysclk);
    #1;
    chk("busy_before_reset", 32'(busy), 32'h1);
    chk("cs_low_before_reset", 32'(m_cs), 32'h0);
    rst = 1'b1; req = '0;
    @(posedge sysclk);
    #1 rst = 1'b0;
    model_ptr = NR - 1;
    repeat (40) @(posedge sysclk);
    #1;
    clear_rem(); rand_data(); rem[0] = 1; rem[1] = 1;
    run_batch(0);

    // Request pulsed for one cycle; data changes right after the grant
    clear_rem(); rand_data(); drive_data();
    make_script(0, sc);
    s = cyc + 1;
    push_txn(rr_pick(model_ptr, 4'b0010), s, sc, a);
    model_ptr = 1;
    req = 4'b0010;
    @(posedge sysclk);
    #1 req = '0;
    rand_data(); drive_data();
    repeat (a - cyc + GP + 2) @(posedge sysclk);
    #1;
    chk("drop_queue_drained", exp_q.size(), 0);

    // Randomised batches
    for (int b = 0; b < 40; b++) begin
      int tot;
      tot = 0;
      rand_data();
      for (int i = 0; i < NR; i++) begin rem[i] = int'($urandom_range(0, 2)); tot += rem[i]; end
      if (tot == 0) rem[$urandom_range(0, NR - 1)] = 1;
      run_batch(-1);
    end

    chk("final_queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=%0d cycles required=completion", cyc);
    $fatal(1, "simulation time limit reached");
  end

endmodule
